uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Sits directly upstream of the clock/baud register file. Accepts command bytes from the UART receiver and buffers them in a small FIFO.
- Drives the register file's address/data/valid request port and waits for ack. On a readback, forwards data_out to the UART transmitter as a response byte.
- Command byte format: bits[7:4] = register address, bits[3:0] = data. Data 4'hF means read.

Parameters:
- FIFO_DEPTH, 4, number of command bytes buffered (power of 2, >=2).
- TIMEOUT_CYCLES, 15, cycles to wait for ack before abandoning a request (>=4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received command byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- address  out  4  register address to the register file
- data  out  4  write data, or 4'hF for read
- valid  out  1  request strobe to the register file (registered)
- ack  in  1  register file acknowledge
- data_out  in  4  register file readback value
- data_out_valid  in  1  readback qualifier; asserted in the same cycle as ack
- tx_data  out  8  response byte to the UART transmitter
- tx_start  out  1  one-cycle strobe to start transmission
- tx_busy  in  1  transmitter busy
- overflow  out  1  one-cycle pulse: rx byte dropped because the FIFO was full
- timeout_err  out  1  one-cycle pulse: request abandoned with no ack

Behaviour:
- All outputs are registered.
- Reset (synchronous) values:
  - address=0, data=0, valid=0, tx_data=0, tx_start=0, overflow=0, timeout_err=0.
  - FIFO is emptied; FSM goes to IDLE.
  - Reset mid-transaction abandons the request and any pending response.
- FIFO:
  - Push on rx_valid when not full.
  - If full and a pop occurs the same cycle, the push is still accepted.
  - If full with no pop, the byte is dropped and overflow pulses the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. A count register of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- FSM states: IDLE, ISSUE, WAIT_ACK, TX_WAIT.
- IDLE:
  - If the FIFO is not empty: pop the head, latch address=byte[7:4] and data=byte[3:0], set valid=1 next cycle, go to ISSUE.
  - Pop-to-valid latency is 1 cycle.
- ISSUE (valid=1 for exactly one cycle):
  - If the address is 0 (register-file reset command, never acked): valid=0 and return to IDLE.
  - Otherwise go to WAIT_ACK and start the timeout counter at 0.
  - valid is a single-cycle pulse so the register file, which samples valid while idle, is not retriggered.
- WAIT_ACK:
  - Counter increments each cycle.
  - If ack=1 and data_out_valid=1: capture tx_data={address, data_out}, go to TX_WAIT.
  - If ack=1 without data_out_valid (a write): go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: pulse timeout_err and go to IDLE. This covers unmapped addresses, which are never acked.
  - If ack and timeout coincide, ack wins.
- TX_WAIT:
  - When tx_busy=0: tx_start=1 for one cycle, then go to IDLE.
  - While tx_busy=1: hold tx_data and stay in TX_WAIT; the FIFO is not popped.
- Next-command latency: the earliest next valid is 2 cycles after leaving WAIT_ACK or TX_WAIT (IDLE pop, then ISSUE).
- Single-outstanding rule: only one request is ever in flight. A new request is never issued while ack could still be pending.
- The FIFO keeps accepting rx bytes in every state.

Test Plan:
- Write: rx 0x13 -> address=1, data=3, valid high 1 cycle; bench acks 1 cycle later -> no tx_start, FSM back in IDLE, no error pulses.
- Read: rx 0xEF, register file returns data_out=0x5 with ack and data_out_valid -> tx_data=0xE5 with one tx_start pulse; no tx_start while tx_busy is held high for 10 cycles; tx_data stays stable throughout.
- Reset command: rx 0x00 -> one-cycle valid with address 0, no wait, timeout_err never pulses; next queued byte issues 2 cycles later.
- Timeout: rx 0x73, never ack -> valid pulse, timeout_err pulses exactly TIMEOUT_CYCLES cycles into WAIT_ACK; next byte then proceeds normally.
- Overflow: stall the FSM with no ack, send 6 back-to-back rx bytes -> the first is popped and in flight, the next 4 fill the FIFO, the 6th pulses overflow; after the timeout the 4 buffered bytes issue in arrival order.
- Reset mid-operation: assert rst during WAIT_ACK with 2 bytes queued -> all outputs return to reset values next cycle, FIFO empty, and no request is issued afterwards.

Source files
------------

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Buffers UART command bytes in a small FIFO and turns each one
//               into a single request to the clock/baud register file.
//               Byte format: [7:4] register address, [3:0] data (4'hF = read).
//               Read results are forwarded to the UART transmitter as
//               {address, data_out}.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] address,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ack,
  input  logic [3:0] data_out,
  input  logic       data_out_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] c_fifo_full = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_issue    = 2'd1;
  localparam logic [1:0] c_st_wait_ack = 2'd2;
  localparam logic [1:0] c_st_tx_wait  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // FSM and datapath registers
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    address_q, address_d;
  logic [3:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d;
  logic          timeout_err_q, timeout_err_d;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_tmo;
  logic [7:0]    w_head;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_fifo_full);
  assign w_head  = mem_q[rd_ptr_q];
  // Head is consumed only when the FSM is free to start a new request
  assign w_pop   = (state_q == c_st_idle) && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push  = rx_valid && (!w_full || w_pop);
  assign w_drop  = rx_valid && w_full && !w_pop;
  assign w_tmo   = (tmo_cnt_q == c_tmo_last);

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO data array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= rx_data;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= c_st_idle;
    else     state_q <= state_d;
  end

  // FSM next-state logic; an ack in the last timeout cycle still wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (!w_empty) state_d = c_st_issue;
      end
      c_st_issue: begin
        // Address 0 resets the register file and is never acknowledged
        state_d = (address_q == 4'h0) ? c_st_idle : c_st_wait_ack;
      end
      c_st_wait_ack: begin
        if (ack)        state_d = data_out_valid ? c_st_tx_wait : c_st_idle;
        else if (w_tmo) state_d = c_st_idle;
      end
      c_st_tx_wait: begin
        if (!tx_busy) state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Next values for the registered outputs and the ack timeout counter
  always_comb begin
    address_d     = address_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    overflow_d    = w_drop;
    timeout_err_d = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    case (state_q)
      c_st_idle: begin
        if (w_pop) begin
          address_d = w_head[7:4];
          data_d    = w_head[3:0];
          valid_d   = 1'b1;
        end
      end
      c_st_issue: begin
        tmo_cnt_d = '0;
      end
      c_st_wait_ack: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (ack && data_out_valid) tx_data_d     = {address_q, data_out};
        else if (!ack && w_tmo)    timeout_err_d = 1'b1;
      end
      c_st_tx_wait: begin
        tx_start_d = !tx_busy;
      end
      default: begin
        tmo_cnt_d = '0;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      address_q     <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      address_q     <= address_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign address     = address_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Directed scoreboard bench for uart_cmd_parser. Expected
//               requests, responses and error pulses are queued as stimulus
//               is issued; a negedge monitor retires them as the DUT shows
//               them. A small register-file model answers requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  typedef struct packed {
    logic [7:0] val;
    int         gap;   // required cycles since previous valid, -1 = any
  } req_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       ack;
  logic [3:0] data_out;
  logic       data_out_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       overflow;
  logic       timeout_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid = -1000;
  int   exp_ov = 0;
  int   exp_to = 0;
  logic ack_mode;
  logic [3:0] rd_value;
  req_t       req_q[$];
  logic [7:0] tx_q[$];

  uart_cmd_parser #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .address(address), .data(data), .valid(valid), .ack(ack),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Register-file model: acks one cycle after valid when enabled; address 0 never acked
  initial begin
    logic [3:0] a;
    logic [3:0] d;
    ack = 1'b0; data_out_valid = 1'b0; data_out = 4'h0;
    forever begin
      @(negedge clk);
      if (valid && ack_mode && address != 4'h0) begin
        a = address;
        d = data;
        @(negedge clk);
        ack = 1'b1;
        data_out_valid = (d == 4'hF);
        data_out = (d == 4'hF) ? rd_value : 4'h0;
        @(negedge clk);
        ack = 1'b0; data_out_valid = 1'b0; data_out = 4'h0;
      end
    end
  end

  // Monitor: retire expected events whenever the DUT presents one
  always @(negedge clk) begin
    req_t e;
    cyc++;
    if (valid) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got %02h expected none", {address, data});
      end else begin
        e = req_q.pop_front();
        if ({address, data} !== e.val) begin
          errors++;
          $display("FAIL req_value: got %02h expected %02h", {address, data}, e.val);
        end else if (e.gap >= 0 && (cyc - last_valid) != e.gap) begin
          errors++;
          $display("FAIL req_gap %02h: got %0d expected %0d", e.val, cyc - last_valid, e.gap);
        end
      end
      last_valid = cyc;
    end
    if (tx_start) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h expected none", tx_data);
      end else if (tx_data !== tx_q[0]) begin
        errors++;
        $display("FAIL tx_data: got %02h expected %02h", tx_data, tx_q[0]);
        void'(tx_q.pop_front());
      end else begin
        void'(tx_q.pop_front());
      end
    end
    if (overflow) begin
      checks++;
      if (exp_ov == 0) begin
        errors++;
        $display("FAIL overflow_unexpected: got 1 expected 0");
      end else exp_ov--;
    end
    if (timeout_err) begin
      checks++;
      if (exp_to == 0) begin
        errors++;
        $display("FAIL timeout_unexpected: got 1 expected 0");
      end else if ((cyc - last_valid) != TMO + 1) begin
        errors++;
        $display("FAIL timeout_time: got %0d expected %0d", cyc - last_valid, TMO + 1);
        exp_to--;
      end else exp_to--;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [7:0] b, input int gap);
    req_t e;
    e.val = b;
    e.gap = gap;
    req_q.push_back(e);
  endtask

  // Called at a negedge; drives one rx strobe and returns at the next negedge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, 32'(address), 32'h0);
    check({tag, "_data"}, 32'(data), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    ack_mode = 1'b0; rd_value = 4'h0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Write: acked one cycle after valid, no response
    ack_mode = 1'b1;
    expect_req(8'h13, -1);
    send(8'h13);
    idle(10);

    // Read held off by tx_busy for 10 cycles
    tx_busy  = 1'b1;
    rd_value = 4'h5;
    expect_req(8'hEF, -1);
    tx_q.push_back(8'hE5);
    send(8'hEF);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      check("busy_no_tx_start", 32'(tx_start), 32'h0);
      check("busy_tx_data_hold", 32'(tx_data), 32'hE5);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    idle(8);

    // Register-file reset command, next byte two cycles later
    expect_req(8'h00, -1);
    expect_req(8'h13, 2);
    send(8'h00);
    send(8'h13);
    idle(12);

    // Timeout, then next byte proceeds
    ack_mode = 1'b0;
    expect_req(8'h73, -1);
    exp_to++;
    expect_req(8'h13, TMO + 2);
    send(8'h73);
    send(8'h13);
    idle(3);
    ack_mode = 1'b1;
    idle(TMO + 10);

    // Overflow: one in flight, four buffered, sixth dropped
    ack_mode = 1'b0;
    expect_req(8'h73, -1);
    exp_to++;
    expect_req(8'h21, TMO + 2);
    expect_req(8'h32, 3);
    expect_req(8'h4F, 3);
    expect_req(8'h54, 4);
    tx_q.push_back(8'h45);
    exp_ov++;
    send(8'h73);
    send(8'h21);
    send(8'h32);
    send(8'h4F);
    send(8'h54);
    send(8'h99);
    idle(2);
    ack_mode = 1'b1;
    idle(TMO + 30);

    // Reset while waiting for ack with two bytes queued
    ack_mode = 1'b0;
    expect_req(8'h73, -1);
    send(8'h73);
    send(8'h81);
    send(8'h92);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(TMO + 20);

    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
    check("overflow_seen", 32'(exp_ov), 32'h0);
    check("timeout_seen", 32'(exp_to), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
